// File: rtl/gen_count_bcd.sv
// Two-digit BCD generation counter: advances once per generation, either from an
// internal prescaler (run) or from single step edges, and pulses gen_tick on each advance.
module gen_count_bcd #(
    parameter int TICK_DIV = 50_000_000,
    parameter bit WRAP     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic       clear,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       gen_tick,
    output logic       wrapped
);

    localparam int            PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          step_q, step_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          tick_q, tick_d;
    logic          wrapped_q, wrapped_d;
    logic          step_rise;
    logic          advance;

    // step_q resets high so a key held through reset is not seen as an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            step_q    <= 1'b1;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            tick_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            step_q    <= step_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            tick_q    <= tick_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_comb begin
        step_d    = step;
        step_rise = step & ~step_q;
        state_d   = state_q;
        pre_d     = '0;
        advance   = 1'b0;
        ones_d    = ones_q;
        tens_d    = tens_q;
        tick_d    = 1'b0;
        wrapped_d = wrapped_q;

        // Advance is decided from the current state, so dropping run on the
        // terminal cycle still yields that generation's advance.
        case (state_q)
            IDLE: begin
                advance = step_rise;
                if (run) state_d = RUN;
            end
            RUN: begin
                advance = (pre_q == PRE_LAST);
                if (!run) begin
                    state_d = IDLE;
                end else if (!advance) begin
                    pre_d = pre_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            pre_d     = '0;
            ones_d    = 4'd0;
            tens_d    = 4'd0;
            wrapped_d = 1'b0;
        end else if (advance) begin
            if (ones_q < 4'd9) begin
                ones_d = ones_q + 4'd1;
                tick_d = 1'b1;
            end else if (tens_q < 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
                tick_d = 1'b1;
            end else if (WRAP) begin
                ones_d    = 4'd0;
                tens_d    = 4'd0;
                wrapped_d = 1'b1;
                tick_d    = 1'b1;
            end
        end
    end

    assign ones     = ones_q;
    assign tens     = tens_q;
    assign gen_tick = tick_q;
    assign wrapped  = wrapped_q;

endmodule
